// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared sizes, read-source encoding and helper for the register file.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int REG_NUM      = 32;
    localparam int REG_NUM_LOG2 = 5;
    localparam int REG_W        = 32;

    typedef enum logic [1:0] {
        RD_SRC_ZERO   = 2'd0,
        RD_SRC_BYPASS = 2'd1,
        RD_SRC_ARRAY  = 2'd2
    } rd_src_e;

    // Read-port source selection in priority order: reset, disabled, r0, bypass, array.
    function automatic rd_src_e rd_src_sel(
        input logic rst_i,
        input logic re_i,
        input logic addr_nz_i,
        input logic bypass_i
    );
        if (rst_i || !re_i || !addr_nz_i) begin
            return RD_SRC_ZERO;
        end
        if (bypass_i) begin
            return RD_SRC_BYPASS;
        end
        return RD_SRC_ARRAY;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module : regfile_scoreboard
// Brief  : Busy-bit scoreboard for in-flight loads plus per-port stall flags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = REG_NUM,
    parameter int ADDR_W   = REG_NUM_LOG2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic                sb_set_i,
    input  logic [ADDR_W-1:0]   sb_addr_i,
    input  logic                flush_i,
    input  logic                re1,
    input  logic [ADDR_W-1:0]   raddr1,
    input  logic                re2,
    input  logic [ADDR_W-1:0]   raddr2,
    output logic                reg1_busy_o,
    output logic                reg2_busy_o,
    output logic [NUM_REGS-1:0] busy_vec_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    function automatic logic busy_at(
        input logic [NUM_REGS-1:0] vec,
        input logic [ADDR_W-1:0]   addr
    );
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_W'(i)) begin
                hit = vec[i];
            end
        end
        return hit;
    endfunction

    // Set is applied after clear so a newer producer wins over the retiring one.
    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (we && (waddr == ADDR_W'(i))) begin
                    busy_d[i] = 1'b0;
                end
                if (sb_set_i && (sb_addr_i == ADDR_W'(i))) begin
                    busy_d[i] = 1'b1;
                end
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A write-back this cycle satisfies the operand through the bypass.
    always_comb begin
        reg1_busy_o = !rst && re1 && (raddr1 != '0) && busy_at(busy_q, raddr1)
                      && !(we && (waddr == raddr1));
        reg2_busy_o = !rst && re2 && (raddr2 != '0) && busy_at(busy_q, raddr2)
                      && !(we && (waddr == raddr2));
    end

    assign busy_vec_o = busy_q;

endmodule

`default_nettype wire

// File: rtl/regfile.sv
// ============================================================================
// Module : regfile
// Brief  : Two-read / one-write register file with write-through bypass and
//          load-use busy scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = REG_NUM,
    parameter int ADDR_W   = REG_NUM_LOG2,
    parameter int DATA_W   = REG_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re1,
    input  logic [ADDR_W-1:0]   raddr1,
    output logic [DATA_W-1:0]   rdata1,
    input  logic                re2,
    input  logic [ADDR_W-1:0]   raddr2,
    output logic [DATA_W-1:0]   rdata2,
    input  logic                sb_set_i,
    input  logic [ADDR_W-1:0]   sb_addr_i,
    input  logic                flush_i,
    output logic                reg1_busy_o,
    output logic                reg2_busy_o,
    output logic [NUM_REGS-1:0] busy_vec_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (we && (waddr == ADDR_W'(i))) begin
                regs_d[i] = wdata;
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    logic              w_re    [2];
    logic [ADDR_W-1:0] w_raddr [2];

    assign w_re[0]    = re1;
    assign w_re[1]    = re2;
    assign w_raddr[0] = raddr1;
    assign w_raddr[1] = raddr2;

    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        logic [DATA_W-1:0] arr_word;
        logic [DATA_W-1:0] rdata_p;
        rd_src_e           src;

        always_comb begin
            arr_word = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_raddr[p] == ADDR_W'(i)) begin
                    arr_word = regs_q[i];
                end
            end
        end

        always_comb begin
            src = rd_src_sel(rst, w_re[p], (w_raddr[p] != '0),
                             (we && (waddr == w_raddr[p])));
            case (src)
                RD_SRC_BYPASS: rdata_p = wdata;
                RD_SRC_ARRAY:  rdata_p = arr_word;
                default:       rdata_p = '0;
            endcase
        end
    end

    assign rdata1 = g_rd_port[0].rdata_p;
    assign rdata2 = g_rd_port[1].rdata_p;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .waddr       (waddr),
        .sb_set_i    (sb_set_i),
        .sb_addr_i   (sb_addr_i),
        .flush_i     (flush_i),
        .re1         (re1),
        .raddr1      (raddr1),
        .re2         (re2),
        .raddr2      (raddr2),
        .reg1_busy_o (reg1_busy_o),
        .reg2_busy_o (reg2_busy_o),
        .busy_vec_o  (busy_vec_o)
    );

endmodule

`default_nettype wire
